// File: rtl/cfg_sequencer_pkg.sv
// Shared types and constants for the SPI-driven configuration sequencer.
// No logic; imported by the sequencer datapath and FSM.
package cfg_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_HOLD
    } state_t;

    localparam logic [7:0] REG_BG    = 8'd0;
    localparam logic [7:0] REG_COLOR = 8'd1;
    localparam logic [7:0] REG_AUDIO = 8'd2;
    localparam logic [7:0] NUM_REGS  = 8'd3;

    localparam logic [7:0] RST_BG    = 8'h00;
    localparam logic [5:0] RST_COLOR = 6'b101010;
    localparam logic       RST_AUDIO = 1'b1;

    function automatic logic [7:0] reg_read(
        input logic [7:0] addr,
        input logic [7:0] bg,
        input logic [5:0] color,
        input logic       audio
    );
        logic [7:0] val;
        val = 8'h00;
        case (addr)
            REG_BG:    val = bg;
            REG_COLOR: val = {2'b00, color};
            REG_AUDIO: val = {7'b0, audio};
            default:   val = 8'h00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/cfg_sequencer_sync2.sv
// Two-flop synchronizer for a single asynchronous pad input.
// Latency: 2 clk cycles; no flow control.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/cfg_sequencer.sv
// SPI slave writing shadow config registers, committed to live outputs at frame start.
// Latency: 4 clk from last SCLK edge to shadow write; SPI has no backpressure (clk >= 8x SCLK).
module cfg_sequencer
    import cfg_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk_in,
    input  logic       ssel_in,
    input  logic       mosi_in,
    input  logic       frame_start,
    output logic       miso,
    output logic [7:0] background_state,
    output logic [5:0] solid_color,
    output logic       audio_en,
    output logic       cfg_update,
    output logic       cmd_err
);

    logic w_sclk, w_ssel, w_mosi;

    sync2 u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk_in), .q(w_sclk));
    sync2 u_sync_ssel (.clk(clk), .rst_n(rst_n), .d(ssel_in), .q(w_ssel));
    sync2 u_sync_mosi (.clk(clk), .rst_n(rst_n), .d(mosi_in), .q(w_mosi));

    logic       r_sclk_d, r_ssel_d;
    logic [1:0] r_warm;
    logic       r_seen_low;
    logic       w_sclk_rise, w_ssel_rise, w_ssel_fall;

    // A select already high when reset releases must not look like a new transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_d   <= 1'b0;
            r_ssel_d   <= 1'b0;
            r_warm     <= 2'd0;
            r_seen_low <= 1'b0;
        end else begin
            r_sclk_d <= w_sclk;
            r_ssel_d <= w_ssel;
            if (r_warm != 2'd3)
                r_warm <= r_warm + 2'd1;
            if (r_warm == 2'd3 && !w_ssel)
                r_seen_low <= 1'b1;
        end
    end

    assign w_sclk_rise = w_sclk & ~r_sclk_d;
    assign w_ssel_rise = w_ssel & ~r_ssel_d & r_seen_low;
    assign w_ssel_fall = ~w_ssel & r_ssel_d;

    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_byte_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 3'd0;
            r_shift     <= 8'h00;
            r_byte_done <= 1'b0;
        end else begin
            r_byte_done <= 1'b0;
            if (w_ssel_fall) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
            end else if (w_sclk_rise && w_ssel) begin
                r_shift     <= {r_shift[6:0], w_mosi};
                r_bit_cnt   <= r_bit_cnt + 3'd1;
                r_byte_done <= (r_bit_cnt == 3'd7);
            end
        end
    end

    state_t     r_state;
    logic [7:0] r_addr;
    logic [7:0] r_rd_shift;
    logic       r_miso, r_cmd_err, r_dirty, r_cfg_update;
    logic [7:0] r_sh_bg, r_bg;
    logic [5:0] r_sh_color, r_color;
    logic       r_sh_audio, r_audio;
    logic [7:0] w_rd_val;

    assign w_rd_val = reg_read(r_shift, r_bg, r_color, r_audio);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_addr       <= 8'h00;
            r_rd_shift   <= 8'h00;
            r_miso       <= 1'b0;
            r_cmd_err    <= 1'b0;
            r_dirty      <= 1'b0;
            r_cfg_update <= 1'b0;
            r_sh_bg      <= RST_BG;
            r_sh_color   <= RST_COLOR;
            r_sh_audio   <= RST_AUDIO;
            r_bg         <= RST_BG;
            r_color      <= RST_COLOR;
            r_audio      <= RST_AUDIO;
        end else begin
            r_cfg_update <= 1'b0;
            // Commit samples the shadows before any same-cycle write; that write re-arms dirty below.
            if (frame_start && r_dirty) begin
                r_bg         <= r_sh_bg;
                r_color      <= r_sh_color;
                r_audio      <= r_sh_audio;
                r_dirty      <= 1'b0;
                r_cfg_update <= 1'b1;
            end
            if (w_ssel_fall) begin
                r_state <= ST_IDLE;
                r_miso  <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_ssel_rise) begin
                            r_state   <= ST_ADDR;
                            r_cmd_err <= 1'b0;
                        end
                    end
                    ST_ADDR: begin
                        if (r_byte_done) begin
                            r_state    <= ST_DATA;
                            r_addr     <= r_shift;
                            r_miso     <= w_rd_val[7];
                            r_rd_shift <= {w_rd_val[6:0], 1'b0};
                            if (r_shift >= NUM_REGS)
                                r_cmd_err <= 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (r_byte_done) begin
                            r_state <= ST_HOLD;
                            r_miso  <= 1'b0;
                            if (r_addr < NUM_REGS) begin
                                case (r_addr)
                                    REG_BG:    r_sh_bg    <= r_shift;
                                    REG_COLOR: r_sh_color <= r_shift[5:0];
                                    REG_AUDIO: r_sh_audio <= r_shift[0];
                                    default:   r_sh_bg    <= r_sh_bg;
                                endcase
                                r_dirty <= 1'b1;
                            end
                        end else if (w_sclk_rise && w_ssel) begin
                            r_miso     <= r_rd_shift[7];
                            r_rd_shift <= {r_rd_shift[6:0], 1'b0};
                        end
                    end
                    default: begin
                        r_state <= ST_HOLD;
                    end
                endcase
            end
        end
    end

    assign miso             = r_miso;
    assign background_state = r_bg;
    assign solid_color      = r_color;
    assign audio_en         = r_audio;
    assign cfg_update       = r_cfg_update;
    assign cmd_err          = r_cmd_err;

endmodule
